condition_code_register: RTL and testbench

- Receiving end of the ALU flag interface. Latches NEGATIVE/ZERO/OVERFLOW/CARRY/INR/IFNR/NOP flags into the 32-bit CCR and drives CCR_Out back to the ALU for ROR/ROL carry-in.
- Resolves branch conditions for BEQ/BNE/BLT/BRA/BSR/JSR/RTS.
- Keeps a LIFO of saved CCR values for subroutine calls.
- Sits between the ALU and the control unit's branch/PC logic.

---
 rtl/alu_defs.sv | 59 +++++
 rtl/ccr_stack.sv | 59 +++++
 rtl/condition_code_register.sv | 131 +++++++++++++
 tb/tb_condition_code_register.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// Shared ALU/CCR definitions: opcode constants, CCR bit positions and the
// opcode-class predicates the condition code register uses.
package alu_defs;

  localparam int OPC_W = 32;

  localparam logic [OPC_W-1:0] OP_NOP = 32'd0;
  localparam logic [OPC_W-1:0] OP_ADD = 32'd1;
  localparam logic [OPC_W-1:0] OP_SUB = 32'd2;
  localparam logic [OPC_W-1:0] OP_JMP = 32'd16;
  localparam logic [OPC_W-1:0] OP_JSR = 32'd17;
  localparam logic [OPC_W-1:0] OP_RTS = 32'd18;
  localparam logic [OPC_W-1:0] OP_BEQ = 32'd39;
  localparam logic [OPC_W-1:0] OP_BNE = 32'd40;
  localparam logic [OPC_W-1:0] OP_BLT = 32'd41;
  localparam logic [OPC_W-1:0] OP_BRA = 32'd64;
  localparam logic [OPC_W-1:0] OP_BSR = 32'd65;

  localparam int CCR_C    = 0;
  localparam int CCR_N    = 1;
  localparam int CCR_V    = 2;
  localparam int CCR_Z    = 3;
  localparam int CCR_INR  = 4;
  localparam int CCR_IFNR = 5;
  localparam int CCR_NOP  = 6;
  localparam int CCR_SAVE_W = 6;

  function automatic logic is_c_op(input logic [OPC_W-1:0] op);
    case (op)
      32'd1, 32'd14, 32'd34, 32'd44, 32'd45,
      32'd9, 32'd10, 32'd11, 32'd12: is_c_op = 1'b1;
      default:                       is_c_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_v_op(input logic [OPC_W-1:0] op);
    case (op)
      32'd1, 32'd14, 32'd34, 32'd44, 32'd45,
      32'd2, 32'd35, 32'd39, 32'd40, 32'd41: is_v_op = 1'b1;
      default:                               is_v_op = 1'b0;
    endcase
  endfunction

  // Control-flow ops leave the arithmetic flags alone.
  function automatic logic is_flag_hold_op(input logic [OPC_W-1:0] op);
    case (op)
      OP_NOP, OP_JMP, OP_JSR, OP_RTS, OP_BRA, OP_BSR: is_flag_hold_op = 1'b1;
      default:                                        is_flag_hold_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_branch_op(input logic [OPC_W-1:0] op);
    case (op)
      OP_BEQ, OP_BNE, OP_BLT, OP_BRA, OP_BSR, OP_JSR, OP_RTS: is_branch_op = 1'b1;
      default:                                                is_branch_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ccr_stack.sv
// LIFO of saved CCR flag fields; the pointer saturates at 0 and DEPTH and
// any push on full or pop on empty sets a sticky error.
module ccr_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic         error
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] ptr_r;
  logic [IDX_W-1:0] top_idx_s;
  logic             error_r;
  logic [W-1:0]     mem_r [DEPTH];

  assign top_idx_s = IDX_W'(ptr_r - PTR_W'(1));
  assign pop_data  = mem_r[top_idx_s];
  assign full      = (ptr_r == PTR_W'(DEPTH));
  assign empty     = (ptr_r == {PTR_W{1'b0}});
  assign error     = error_r;

  // Pointer and sticky error tracking.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_r   <= {PTR_W{1'b0}};
      error_r <= 1'b0;
    end else if (push) begin
      if (full) begin
        error_r <= 1'b1;
      end else begin
        ptr_r <= ptr_r + PTR_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        error_r <= 1'b1;
      end else begin
        ptr_r <= ptr_r - PTR_W'(1);
      end
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge Clock) begin
    if (push && !full) begin
      mem_r[ptr_r[IDX_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/condition_code_register.sv
// Condition code register: latches ALU flags, resolves branch conditions
// and saves/restores the flag field across subroutine calls.
module condition_code_register
  import alu_defs::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int OP_W        = 32
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic [OP_W-1:0] ALU_Op,
  input  logic            CCR_Enable,
  input  logic            NOP_FLAG,
  input  logic            INR_FLAG,
  input  logic            IFNR_FLAG,
  input  logic            NEGATIVE_FLAG,
  input  logic            ZERO_FLAG,
  input  logic            OVERFLOW_FLAG,
  input  logic            CARRY_FLAG,
  output logic [31:0]     CCR_Out,
  output logic            Branch_Valid,
  output logic            Branch_Taken,
  output logic            Stack_Full,
  output logic            Stack_Empty,
  output logic            Stack_Error
);

  logic [OPC_W-1:0]      op_s;
  logic                  exec_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  error_s;
  logic [CCR_SAVE_W-1:0] pop_data_s;
  logic [CCR_SAVE_W-1:0] flags_next_s;
  logic                  taken_next_s;
  logic [CCR_NOP:0]      ccr_r;
  logic                  branch_valid_r;
  logic                  branch_taken_r;

  assign op_s   = OPC_W'(ALU_Op);
  assign exec_s = CCR_Enable & ~NOP_FLAG;
  assign push_s = exec_s & ((op_s == OP_JSR) | (op_s == OP_BSR));
  assign pop_s  = exec_s & (op_s == OP_RTS);

  ccr_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (CCR_SAVE_W)
  ) u_stack (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (ccr_r[CCR_SAVE_W-1:0]),
    .pop_data  (pop_data_s),
    .full      (full_s),
    .empty     (empty_s),
    .error     (error_s)
  );

  // Next value of the flag field C/N/V/Z/INR/IFNR.
  always_comb begin
    flags_next_s = ccr_r[CCR_SAVE_W-1:0];
    if (NOP_FLAG) begin
      flags_next_s = ccr_r[CCR_SAVE_W-1:0];
    end else if (op_s == OP_RTS) begin
      if (!empty_s) begin
        flags_next_s = pop_data_s;
      end else begin
        flags_next_s = ccr_r[CCR_SAVE_W-1:0];
      end
    end else if (is_flag_hold_op(op_s)) begin
      flags_next_s = ccr_r[CCR_SAVE_W-1:0];
    end else begin
      flags_next_s[CCR_INR]  = INR_FLAG;
      flags_next_s[CCR_IFNR] = IFNR_FLAG;
      flags_next_s[CCR_Z]    = ZERO_FLAG;
      flags_next_s[CCR_N]    = NEGATIVE_FLAG;
      if (is_c_op(op_s)) begin
        flags_next_s[CCR_C] = CARRY_FLAG;
      end else begin
        flags_next_s[CCR_C] = ccr_r[CCR_C];
      end
      if (is_v_op(op_s)) begin
        flags_next_s[CCR_V] = OVERFLOW_FLAG;
      end else begin
        flags_next_s[CCR_V] = ccr_r[CCR_V];
      end
    end
  end

  // Branch conditions look at the live ALU flags, not the stored CCR.
  always_comb begin
    taken_next_s = 1'b0;
    case (op_s)
      OP_BEQ:                         taken_next_s = ZERO_FLAG;
      OP_BNE:                         taken_next_s = ~ZERO_FLAG;
      OP_BLT:                         taken_next_s = NEGATIVE_FLAG ^ OVERFLOW_FLAG;
      OP_BRA, OP_BSR, OP_JSR, OP_RTS: taken_next_s = 1'b1;
      default:                        taken_next_s = 1'b0;
    endcase
  end

  // CCR and branch result registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ccr_r          <= 7'd0;
      branch_valid_r <= 1'b0;
      branch_taken_r <= 1'b0;
    end else if (CCR_Enable) begin
      ccr_r <= {NOP_FLAG, flags_next_s};
      if (!NOP_FLAG && is_branch_op(op_s)) begin
        branch_valid_r <= 1'b1;
        branch_taken_r <= taken_next_s;
      end else begin
        branch_valid_r <= 1'b0;
      end
    end else begin
      branch_valid_r <= 1'b0;
    end
  end

  assign CCR_Out      = {25'd0, ccr_r};
  assign Branch_Valid = branch_valid_r;
  assign Branch_Taken = branch_taken_r;
  assign Stack_Full   = full_s;
  assign Stack_Empty  = empty_s;
  assign Stack_Error  = error_s;

endmodule

// File: tb/tb_condition_code_register.sv
// Directed bench for condition_code_register: a vector table for the flag
// and branch rules plus hand sequences for reset, stack order and overflow.
module tb_condition_code_register;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [31:0] ALU_Op;
  logic        CCR_Enable, NOP_FLAG, INR_FLAG, IFNR_FLAG;
  logic        NEGATIVE_FLAG, ZERO_FLAG, OVERFLOW_FLAG, CARRY_FLAG;
  logic [31:0] CCR_Out;
  logic        Branch_Valid, Branch_Taken, Stack_Full, Stack_Empty, Stack_Error;

  int n_vec = 0;
  int n_err = 0;

  condition_code_register #(.STACK_DEPTH(4), .OP_W(32)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .ALU_Op(ALU_Op), .CCR_Enable(CCR_Enable),
    .NOP_FLAG(NOP_FLAG), .INR_FLAG(INR_FLAG), .IFNR_FLAG(IFNR_FLAG),
    .NEGATIVE_FLAG(NEGATIVE_FLAG), .ZERO_FLAG(ZERO_FLAG),
    .OVERFLOW_FLAG(OVERFLOW_FLAG), .CARRY_FLAG(CARRY_FLAG),
    .CCR_Out(CCR_Out), .Branch_Valid(Branch_Valid), .Branch_Taken(Branch_Taken),
    .Stack_Full(Stack_Full), .Stack_Empty(Stack_Empty), .Stack_Error(Stack_Error)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        en, nop, inr, ifnr, n, z, v, c;
    logic [31:0] op;
    logic [31:0] ccr;
    logic        bv, bt, empty;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic en, input int op, input logic nop,
                              input logic inr, input logic ifnr, input logic n,
                              input logic z, input logic v, input logic c,
                              input int ccr, input logic bv, input logic bt,
                              input logic empty);
    vec_t r;
    r.en = en; r.op = op; r.nop = nop; r.inr = inr; r.ifnr = ifnr;
    r.n = n; r.z = z; r.v = v; r.c = c; r.ccr = ccr;
    r.bv = bv; r.bt = bt; r.empty = empty;
    return r;
  endfunction

  task automatic step(input logic en, input int op, input logic nop,
                      input logic inr, input logic ifnr, input logic n,
                      input logic z, input logic v, input logic c);
    @(negedge Clock);
    CCR_Enable = en; ALU_Op = op; NOP_FLAG = nop; INR_FLAG = inr;
    IFNR_FLAG = ifnr; NEGATIVE_FLAG = n; ZERO_FLAG = z;
    OVERFLOW_FLAG = v; CARRY_FLAG = c;
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] ccr, input logic bv,
                       input logic bt, input logic full, input logic empty,
                       input logic err);
    n_vec++;
    if (CCR_Out !== ccr) begin
      n_err++;
      $display("FAIL %s ccr: got %h expected %h", name, CCR_Out, ccr);
    end
    if (Branch_Valid !== bv) begin
      n_err++;
      $display("FAIL %s branch_valid: got %b expected %b", name, Branch_Valid, bv);
    end
    if (Branch_Taken !== bt) begin
      n_err++;
      $display("FAIL %s branch_taken: got %b expected %b", name, Branch_Taken, bt);
    end
    if (Stack_Full !== full) begin
      n_err++;
      $display("FAIL %s full: got %b expected %b", name, Stack_Full, full);
    end
    if (Stack_Empty !== empty) begin
      n_err++;
      $display("FAIL %s empty: got %b expected %b", name, Stack_Empty, empty);
    end
    if (Stack_Error !== err) begin
      n_err++;
      $display("FAIL %s error: got %b expected %b", name, Stack_Error, err);
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    CCR_Enable = 1'b0; Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0; CCR_Enable = 1'b0; ALU_Op = 32'd0; NOP_FLAG = 1'b0;
    INR_FLAG = 1'b0; IFNR_FLAG = 1'b0; NEGATIVE_FLAG = 1'b0; ZERO_FLAG = 1'b0;
    OVERFLOW_FLAG = 1'b0; CARRY_FLAG = 1'b0;

    //             en op  nop inr ifnr n  z  v  c  ccr   bv bt empty
    tbl[0]  = mk(1,  1, 0, 0, 0, 0, 1, 0, 1, 'h09, 0, 0, 1);
    tbl[1]  = mk(1,  3, 0, 0, 0, 1, 0, 0, 0, 'h03, 0, 0, 1);
    tbl[2]  = mk(1, 41, 0, 0, 0, 1, 0, 0, 0, 'h03, 1, 1, 1);
    tbl[3]  = mk(1, 39, 0, 0, 0, 0, 0, 0, 0, 'h01, 1, 0, 1);
    tbl[4]  = mk(1, 13, 0, 0, 0, 0, 1, 0, 0, 'h09, 0, 0, 1);
    tbl[5]  = mk(0,  1, 0, 1, 1, 1, 0, 1, 0, 'h09, 0, 0, 1);
    tbl[6]  = mk(1,  1, 1, 0, 0, 0, 1, 0, 1, 'h49, 0, 0, 1);
    tbl[7]  = mk(1,  1, 0, 1, 0, 0, 0, 1, 0, 'h14, 0, 0, 1);
    tbl[8]  = mk(1, 17, 0, 0, 0, 1, 1, 0, 1, 'h14, 1, 1, 0);
    tbl[9]  = mk(1,  2, 0, 0, 0, 1, 0, 0, 1, 'h02, 0, 1, 0);
    tbl[10] = mk(1, 18, 0, 0, 0, 0, 0, 0, 0, 'h14, 1, 1, 1);
    tbl[11] = mk(1, 40, 0, 0, 0, 0, 1, 0, 1, 'h08, 1, 0, 1);
    tbl[12] = mk(1, 16, 0, 1, 1, 1, 0, 1, 1, 'h08, 0, 0, 1);
    tbl[13] = mk(1,  1, 1, 0, 0, 1, 1, 1, 1, 'h48, 0, 0, 1);
    tbl[14] = mk(1, 64, 0, 0, 0, 0, 0, 0, 0, 'h08, 1, 1, 1);
    tbl[15] = mk(1, 41, 0, 0, 0, 1, 0, 1, 0, 'h06, 1, 0, 1);
    tbl[16] = mk(1,  9, 0, 0, 0, 0, 0, 0, 1, 'h05, 0, 0, 1);
    tbl[17] = mk(1, 45, 0, 0, 1, 0, 0, 0, 0, 'h20, 0, 0, 1);

    #12;
    check("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge Clock);
    Reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].en, int'(tbl[i].op), tbl[i].nop, tbl[i].inr, tbl[i].ifnr,
           tbl[i].n, tbl[i].z, tbl[i].v, tbl[i].c);
      check($sformatf("vec%0d", i), tbl[i].ccr, tbl[i].bv, tbl[i].bt,
            1'b0, tbl[i].empty, 1'b0);
    end

    // Pop on empty, then async reset in the middle of a push burst.
    do_reset();
    step(1, 18, 0, 0, 0, 0, 0, 0, 0);
    check("pop_empty", 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 1);
    check("set_c", 32'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1, 65, 0, 0, 0, 0, 0, 0, 0);
      check($sformatf("push%0d", i), 32'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge Clock);
    CCR_Enable = 1'b0;
    Reset_n = 1'b1;

    // NOP from reset, LIFO order, overflow and draining back to empty.
    step(1, 1, 1, 0, 0, 0, 1, 0, 1);
    check("nop_only", 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 1);
    check("lf_a", 32'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1, 65, 0, 0, 0, 0, 0, 0, 0);
    check("lf_push1", 32'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1, 1, 0, 0, 0, 0, 1, 0, 0);
    check("lf_b", 32'h08, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      step(1, 65, 0, 0, 0, 0, 0, 0, 0);
      check($sformatf("lf_push%0d", i), 32'h08, 1'b1, 1'b1, (i == 4), 1'b0, 1'b0);
    end
    step(1, 65, 0, 0, 0, 0, 0, 0, 0);
    check("overflow", 32'h08, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("lf_clear", 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1, 18, 0, 0, 0, 0, 0, 0, 0);
    check("pop4", 32'h08, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("lf_clear2", 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1, 18, 0, 0, 0, 0, 0, 0, 0);
    check("pop3", 32'h08, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1, 18, 0, 0, 0, 0, 0, 0, 0);
    check("pop2", 32'h08, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1, 18, 0, 0, 0, 0, 0, 0, 0);
    check("pop1", 32'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(0, 18, 0, 0, 0, 0, 0, 0, 0);
    check("idle", 32'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
